// File: rtl/stp_pkg.sv
// Shared types and helpers for the flex_stp_word_rx serial-to-parallel receiver.
package stp_pkg;

    // Holding-register handshake state: EMPTY means out_valid = 0, FULL means out_valid = 1.
    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_t;

    // Width of a counter that has to reach n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stp_bit_counter.sv
// Counts received bits within a word. The wrap pulse marks the shift that completes a word.
module stp_bit_counter
    import stp_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           clear,
    input  logic                           count_enable,
    output logic [cnt_width(NUM_BITS)-1:0] count,
    output logic                           wrap
);

    localparam int             CW   = cnt_width(NUM_BITS);
    localparam logic [CW-1:0]  LAST = CW'(NUM_BITS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap is a same-cycle strobe, so the top can capture the word on the completing edge.
    assign wrap  = count_enable && (count_q == LAST);
    assign count = count_q;

    // Next count: clear wins, then increment with wrap back to zero after the last bit.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flex_stp_word_rx.sv
// Serial-to-parallel word receiver: shift register, bit counter, and a one-entry
// holding register presented on a valid/ready handshake with a sticky overrun flag.
module flex_stp_word_rx
    import stp_pkg::*;
#(
    parameter int                  NUM_BITS  = 8,
    parameter bit                  SHIFT_MSB = 1'b1,
    parameter logic [NUM_BITS-1:0] RESET_VAL = '1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           shift_enable,
    input  logic                           serial_in,
    input  logic                           clear,
    input  logic                           out_ready,
    output logic [NUM_BITS-1:0]            parallel_out,
    output logic [cnt_width(NUM_BITS)-1:0] bit_count,
    output logic [NUM_BITS-1:0]            data_out,
    output logic                           out_valid,
    output logic                           word_done,
    output logic                           overrun
);

    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] shifted;
    logic [NUM_BITS-1:0] data_q, data_d;
    hold_state_t         state_q, state_d;
    logic                word_done_q, word_done_d;
    logic                overrun_q, overrun_d;

    logic                count_enable;
    logic                completion;
    logic                load_word;
    logic                drop_word;

    // clear takes priority over shifting, so it also suppresses counting and completion.
    assign count_enable = shift_enable && !clear;

    stp_bit_counter #(
        .NUM_BITS     (NUM_BITS)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (count_enable),
        .count        (bit_count),
        .wrap         (completion)
    );

    // The shifted value includes the current bit; on completion it is the finished word.
    assign shifted = SHIFT_MSB ? {shift_q[NUM_BITS-2:0], serial_in}
                               : {serial_in, shift_q[NUM_BITS-1:1]};

    // Shift register next value: clear, then shift, then hold.
    always_comb begin
        shift_d = shift_q;
        if (clear) begin
            shift_d = RESET_VAL;
        end else if (shift_enable) begin
            shift_d = shifted;
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake FSM next state; a completion while FULL keeps FULL whether stored or dropped.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = HOLD_EMPTY;
        end else begin
            case (state_q)
                HOLD_EMPTY: if (completion) state_d = HOLD_FULL;
                HOLD_FULL:  if (!completion && out_ready) state_d = HOLD_EMPTY;
                default:    state_d = HOLD_EMPTY;
            endcase
        end
    end

    // Handshake FSM outputs: valid flag plus load/drop strobes for the holding register.
    always_comb begin
        out_valid = (state_q == HOLD_FULL);
        load_word = completion && ((state_q == HOLD_EMPTY) || out_ready);
        drop_word = completion && (state_q == HOLD_FULL) && !out_ready;
    end

    // Holding register, word_done pulse and sticky overrun next values.
    always_comb begin
        data_d      = data_q;
        word_done_d = completion;
        overrun_d   = overrun_q;
        if (clear) begin
            overrun_d = 1'b0;
        end else begin
            if (load_word) data_d    = shifted;
            if (drop_word) overrun_d = 1'b1;
        end
    end

    // Datapath and flag registers; a reset mid-word discards partial and pending words.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q     <= RESET_VAL;
            data_q      <= '0;
            word_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            data_q      <= data_d;
            word_done_q <= word_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign parallel_out = shift_q;
    assign data_out     = data_q;
    assign word_done    = word_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_flex_stp_word_rx.sv
// Self-checking bench: an MSB-first and an LSB-first receiver share one input stream
// and are compared every cycle against a bit-history reference model.
module tb_flex_stp_word_rx;

    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic clk = 1'b0;
    logic n_rst;
    logic shift_enable, serial_in, clear, out_ready;

    logic [N-1:0]  po_m, po_l, do_m, do_l;
    logic [CW-1:0] bc_m, bc_l;
    logic          ov_m, ov_l, wd_m, wd_l, orn_m, orn_l;

    int n_checks = 0;
    int n_errors = 0;
    int wd_pulses;

    always #5 clk = ~clk;

    flex_stp_word_rx #(.NUM_BITS(N), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .clear(clear), .out_ready(out_ready), .parallel_out(po_m), .bit_count(bc_m),
        .data_out(do_m), .out_valid(ov_m), .word_done(wd_m), .overrun(orn_m)
    );

    flex_stp_word_rx #(.NUM_BITS(N), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .clear(clear), .out_ready(out_ready), .parallel_out(po_l), .bit_count(bc_l),
        .data_out(do_l), .out_valid(ov_l), .word_done(wd_l), .overrun(orn_l)
    );

    // ---------------- reference model ----------------
    // The model keeps the raw bit history since reset/clear (idle ones prefilled) and
    // derives both bit orders from it; words are simply windows of the last N bits.
    bit          hist[$];
    int          m_cnt;
    bit          m_valid, m_wd, m_ovr;
    logic [N-1:0] m_data_m, m_data_l;

    function automatic logic [N-1:0] win_msb();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = hist[hist.size() - 1 - i];
        return r;
    endfunction

    function automatic logic [N-1:0] win_lsb();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[N - 1 - i] = hist[hist.size() - 1 - i];
        return r;
    endfunction

    task automatic fill_idle();
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(1'b1);
    endtask

    task automatic model_reset();
        fill_idle();
        m_cnt = 0; m_valid = 0; m_wd = 0; m_ovr = 0;
        m_data_m = '0; m_data_l = '0;
    endtask

    task automatic model_edge(input bit se, input bit sb, input bit clr, input bit rdy);
        bit comp;
        if (clr) begin
            fill_idle();
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_wd = 0;
        end else begin
            comp = 0;
            if (se) begin
                hist.push_back(sb);
                if (hist.size() > N) void'(hist.pop_front());
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt = 0;
                    comp  = 1;
                end
            end
            m_wd = comp;
            if (comp) begin
                if (!m_valid || rdy) begin
                    m_data_m = win_msb();
                    m_data_l = win_lsb();
                    m_valid  = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("po_msb",  32'(po_m),  32'(win_msb()));
        check("po_lsb",  32'(po_l),  32'(win_lsb()));
        check("bc_msb",  32'(bc_m),  32'(m_cnt));
        check("bc_lsb",  32'(bc_l),  32'(m_cnt));
        check("do_msb",  32'(do_m),  32'(m_data_m));
        check("do_lsb",  32'(do_l),  32'(m_data_l));
        check("vld_msb", 32'(ov_m),  32'(m_valid));
        check("vld_lsb", 32'(ov_l),  32'(m_valid));
        check("wd_msb",  32'(wd_m),  32'(m_wd));
        check("wd_lsb",  32'(wd_l),  32'(m_wd));
        check("ovr_msb", 32'(orn_m), 32'(m_ovr));
        check("ovr_lsb", 32'(orn_l), 32'(m_ovr));
    endtask

    // One clock: drive inputs, take the edge, update the model, sample #1 after the edge.
    task automatic step(input bit se, input bit sb, input bit clr, input bit rdy);
        shift_enable = se;
        serial_in    = sb;
        clear        = clr;
        out_ready    = rdy;
        @(posedge clk);
        model_edge(se, sb, clr, rdy);
        #1;
        if (wd_m) wd_pulses++;
        compare_all();
    endtask

    // Sends a word MSB first on the wire; out_ready is asserted only on the final bit.
    task automatic send_word(input logic [N-1:0] w, input bit rdy_last);
        for (int i = N - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
    endtask

    initial begin
        logic [N-1:0] w_a;
        logic [N-1:0] w_b;
        w_a = 8'hC1;
        w_b = 8'h3C;
        wd_pulses = 0;

        n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_po",  32'(po_m), 32'hFF);
        check("rst_vld", 32'(ov_m), 32'h0);
        n_rst = 1'b1;

        // Test 1: asynchronous reset after three bits, observed with no clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        check("t1_po_msb", 32'(po_m),  32'hFF);
        check("t1_po_lsb", 32'(po_l),  32'hFF);
        check("t1_bc",     32'(bc_m),  32'h0);
        check("t1_vld",    32'(ov_m),  32'h0);
        check("t1_ovr",    32'(orn_m), 32'h0);
        model_reset();
        #1 n_rst = 1'b1;

        // Test 2: single word, out_ready low; both bit orders from the same stream.
        send_word(w_a, 1'b0);
        check("t2_do_msb", 32'(do_m), 32'hC1);
        check("t2_do_lsb", 32'(do_l), 32'h83);
        check("t2_vld",    32'(ov_m), 32'h1);
        check("t2_wd",     32'(wd_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_wd_end", 32'(wd_m), 32'h0);
        check("t2_hold",   32'(do_m), 32'hC1);

        // Test 3: back-to-back words, ready pulsed on the completing cycle of word two.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(w_a, 1'b0);
        send_word(w_b, 1'b1);
        check("t3_vld",    32'(ov_m),  32'h1);
        check("t3_do_msb", 32'(do_m),  32'h3C);
        check("t3_ovr",    32'(orn_m), 32'h0);

        // Test 4: overrun when the consumer never accepts.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        wd_pulses = 0;
        send_word(w_a, 1'b0);
        send_word(w_b, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_do_msb", 32'(do_m),  32'hC1);
        check("t4_ovr",    32'(orn_m), 32'h1);
        check("t4_pulses", 32'(wd_pulses), 32'd2);

        // Test 5: clear mid-word with shift_enable also high.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_bc",  32'(bc_m),  32'h0);
        check("t5_po",  32'(po_m),  32'hFF);
        check("t5_vld", 32'(ov_m),  32'h0);
        check("t5_ovr", 32'(orn_m), 32'h0);
        send_word(w_a, 1'b0);
        check("t5_do_msb", 32'(do_m), 32'hC1);
        check("t5_do_lsb", 32'(do_l), 32'h83);

        // Test 6: gapped random input with the consumer always ready.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            n_checks++;
            if (bc_m > CW'(N - 1)) begin
                n_errors++;
                $display("FAIL t6_bc_range: got %0d expected <= %0d", bc_m, N - 1);
            end
        end

        // Random mix of ready, clear and shifting to exercise every handshake transition.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flex_stp_word_rx.md
Name: flex_stp_word_rx

Overview:
Parametrised serial-to-parallel receiver and successor to the flexible stp shift register. It shifts serial bits into a NUM_BITS-wide register, counts bits, and assembles complete words. Each completed word is transferred into a holding register and presented on a valid/ready handshake. It sits between bit-level front ends (line decoders, edge detectors) and word-level consumers such as FIFOs and packet FSMs.

Parameters:
- NUM_BITS, 8: word width; legal range 2..32.
- SHIFT_MSB, 1: 1 = MSB-first (serial_in enters bit 0, data moves toward the MSB); 0 = LSB-first (serial_in enters bit NUM_BITS-1, data moves toward bit 0).
- RESET_VAL, all ones: value of the shift register after reset and after clear (idle line is high).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- shift_enable  in  1  sample serial_in this cycle.
- serial_in  in  1  serial data bit.
- clear  in  1  synchronous clear of the frame and handshake state.
- out_ready  in  1  consumer accepts data_out.
- parallel_out  out  NUM_BITS  live view of the shift register.
- bit_count  out  $clog2(NUM_BITS)  bits received in the current word, 0..NUM_BITS-1.
- data_out  out  NUM_BITS  holding register with the last accepted word.
- out_valid  out  1  data_out holds an unconsumed word.
- word_done  out  1  one-cycle pulse, the cycle after any word completes.
- overrun  out  1  sticky flag: a word was dropped.

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous and active-low.
- Reset values: parallel_out = RESET_VAL, bit_count = 0, data_out = 0, out_valid = 0, word_done = 0, overrun = 0.
- Reset asserted mid-word discards the partial word and any pending word.
- All outputs are registered; there are no combinational input-to-output paths.
- Priority each edge: clear, then shift, then hold.
- clear = 1:
  - parallel_out = RESET_VAL, bit_count = 0, out_valid = 0, overrun = 0, word_done = 0.
  - data_out is held.
  - shift_enable is ignored that cycle.
- Shift (shift_enable = 1, clear = 0):
  - SHIFT_MSB = 1: next = {parallel_out[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB = 0: next = {serial_in, parallel_out[NUM_BITS-1:1]}.
  - bit_count increments.
- Completion: a shift taken while bit_count == NUM_BITS-1.
  - bit_count wraps to 0.
  - The completed word is the next shift-register value (including the current bit).
  - word_done = 1 on the following cycle, whether the word was stored or dropped.
- Holding handshake, two-state FSM with states EMPTY (out_valid = 0) and FULL (out_valid = 1):
  - EMPTY + completion -> FULL; data_out = completed word.
  - FULL + out_ready, no completion -> EMPTY.
  - FULL + out_ready + completion in the same cycle -> stays FULL; data_out = new word; no overrun.
  - FULL + no out_ready + completion -> stays FULL; the new word is dropped, data_out keeps the old word, overrun is set.
  - out_ready while EMPTY has no effect.
- overrun is cleared only by clear or reset.
- Latency: the final bit is sampled at edge N; data_out, out_valid and word_done update at edge N. Visibility is one cycle after the final shift_enable cycle.
- Back-to-back words with shift_enable held high continuously are supported with no bubble.
- With shift_enable = 0, the shift register and bit_count hold indefinitely; there is no timeout.
- data_out is stable while out_valid = 1 and out_ready = 0.

Decomposition:
- Package stp_pkg holds:
  - typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t.
  - Function cnt_width(n), returning $clog2(n).
- One sub-module, stp_bit_counter (parameter NUM_BITS), instantiated once. Inputs: clk, n_rst, clear, count_enable. Outputs: count and a wrap pulse.
- The shift register, holding register and FSM stay in the top module.

Test Plan:
1. Reset: assert n_rst = 0 asynchronously mid-word (after 3 bits) -> parallel_out = 8'hFF, bit_count = 0, out_valid = 0, overrun = 0, immediately and without a clock edge.
2. MSB-first, NUM_BITS = 8: shift 1,1,0,0,0,0,0,1 with out_ready = 0 -> data_out = 8'hC1, out_valid = 1 and word_done pulse one cycle after the 8th bit. Rerun with SHIFT_MSB = 0 -> data_out = 8'h83.
3. Back-to-back: shift_enable held high for 16 bits (8'hC1 then 8'h3C), out_ready pulsed in the cycle the 2nd word completes -> out_valid stays 1, data_out = 8'h3C, overrun = 0.
4. Overrun: two words (8'hC1, 8'h3C) with out_ready = 0 throughout -> data_out remains 8'hC1, overrun = 1, two word_done pulses.
5. Clear mid-word: clear after 5 bits with shift_enable = 1 in the same cycle -> bit_count = 0, parallel_out = 8'hFF, out_valid = 0, overrun = 0; the next 8 bits form a clean word.
6. Gapped input: shift_enable toggled at random with out_ready = 1 -> data_out matches a scoreboard word model; bit_count never exceeds NUM_BITS-1.
